// File: rtl/vec_instr_assembler_if.sv
// Control-bus beat input plus instruction-FIFO push side of the vector instruction assembler.
// slave is the assembler's view; master is the driver/FIFO side.
interface vec_instr_assembler_if #(
   parameter int DATA_WIDTH      = 64,
   parameter int VEC_INSTR_WIDTH = 32
);
   localparam int INSTR_WIDTH = 3*DATA_WIDTH - VEC_INSTR_WIDTH;

   logic [DATA_WIDTH-1:0]  s_data;
   logic                   s_valid;
   logic                   s_ready;
   logic                   flush;
   logic                   fifo_full;
   logic                   push;
   logic [INSTR_WIDTH-1:0] push_data;
   logic [1:0]             beat_cnt;
   logic [15:0]            instr_count;

   modport master (
      output s_data, s_valid, flush, fifo_full,
      input  s_ready, push, push_data, beat_cnt, instr_count
   );

   modport slave (
      input  s_data, s_valid, flush, fifo_full,
      output s_ready, push, push_data, beat_cnt, instr_count
   );
endinterface

// File: rtl/vec_instr_assembler.sv
// Packs three control-bus beats into one instruction word; push the cycle after beat 2 is accepted.
// A full FIFO with a word still pending stalls only beat 2; beats 0 and 1 keep flowing.
module vec_instr_assembler #(
   parameter int  DATA_WIDTH      = 64,
   parameter int  VEC_INSTR_WIDTH = 32,
   localparam int INSTR_WIDTH     = 3*DATA_WIDTH - VEC_INSTR_WIDTH
) (
   input logic                  CLK,
   input logic                  RESET,
   vec_instr_assembler_if.slave bus
);
   typedef enum logic [1:0] {
      BEAT0 = 2'd0,
      BEAT1 = 2'd1,
      BEAT2 = 2'd2
   } beat_e;

   beat_e                   state;
   beat_e                   state_nxt;
   logic [2*DATA_WIDTH-1:0] staging;
   logic [INSTR_WIDTH-1:0]  out_reg;
   logic                    pending;
   logic [15:0]             count_q;
   logic                    ready_int;
   logic                    accept;
   logic                    push_int;

   // Upper bits of beat 2 carry nothing for the instruction word.
   logic unused_upper;
   assign unused_upper = ^bus.s_data[DATA_WIDTH-1:DATA_WIDTH-VEC_INSTR_WIDTH];

   always_comb begin
      state_nxt = state;
      ready_int = 1'b0;
      if (!bus.flush) begin
         ready_int = (state != BEAT2) || !pending || !bus.fifo_full;
      end
      accept   = bus.s_valid && ready_int;
      push_int = pending && !bus.fifo_full;
      if (bus.flush) begin
         state_nxt = BEAT0;
      end else if (accept) begin
         case (state)
            BEAT0:   state_nxt = BEAT1;
            BEAT1:   state_nxt = BEAT2;
            default: state_nxt = BEAT0;
         endcase
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= BEAT0;
         staging <= '0;
         out_reg <= '0;
         pending <= 1'b0;
         count_q <= '0;
      end else begin
         state <= state_nxt;
         if (push_int) begin
            count_q <= count_q + 16'd1;
         end
         if (bus.flush) begin
            staging <= '0;
         end else if (accept && state == BEAT0) begin
            staging[DATA_WIDTH-1:0] <= bus.s_data;
         end else if (accept && state == BEAT1) begin
            staging[2*DATA_WIDTH-1:DATA_WIDTH] <= bus.s_data;
         end
         // A new beat 2 landing on a push cycle keeps pending set and reloads the word.
         if (accept && state == BEAT2) begin
            out_reg <= {bus.s_data[DATA_WIDTH-VEC_INSTR_WIDTH-1:0], staging};
            pending <= 1'b1;
         end else if (push_int) begin
            pending <= 1'b0;
         end
      end
   end

   assign bus.s_ready     = ready_int;
   assign bus.push        = push_int;
   assign bus.push_data   = out_reg;
   assign bus.beat_cnt    = state;
   assign bus.instr_count = count_q;
endmodule

// File: tb/tb_vec_instr_assembler.sv
// Bench for vec_instr_assembler: directed vector table, corner-case sequences and a randomized run
// checked against a beat-queue reference model.
module tb_vec_instr_assembler;
   localparam int DW = 64;
   localparam int VW = 32;
   localparam int IW = 3*DW - VW;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;
   int   push_seen;

   vec_instr_assembler_if #(.DATA_WIDTH(DW), .VEC_INSTR_WIDTH(VW)) bus ();

   vec_instr_assembler #(.DATA_WIDTH(DW), .VEC_INSTR_WIDTH(VW)) dut (
      .CLK   (clk),
      .RESET (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: beats of the instruction in progress, the completed word awaiting the FIFO, push count.
   logic [DW-1:0] cur[$];
   logic          m_pend;
   logic [IW-1:0] m_word;
   logic [15:0]   m_cnt;

   typedef struct {
      logic          v;
      logic [DW-1:0] d;
      logic          ff;
      logic          e_rdy;
      logic          e_push;
      logic [IW-1:0] e_pd;
      logic [1:0]    e_bc;
      logic [15:0]   e_cnt;
   } vec_t;

   vec_t tbl[16];

   task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v, input logic [DW-1:0] d, input logic ff, input logic e_rdy,
                               input logic e_push, input logic [IW-1:0] e_pd, input logic [1:0] e_bc,
                               input logic [15:0] e_cnt);
      vec_t r;
      r.v = v; r.d = d; r.ff = ff; r.e_rdy = e_rdy; r.e_push = e_push;
      r.e_pd = e_pd; r.e_bc = e_bc; r.e_cnt = e_cnt;
      return r;
   endfunction

   function automatic logic [IW-1:0] word(input logic [DW-1:0] b0, input logic [DW-1:0] b1,
                                          input logic [DW-1:0] b2);
      return {b2[DW-VW-1:0], b1, b0};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      bus.s_valid = 1'b0; bus.s_data = '0; bus.flush = 1'b0; bus.fifo_full = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      cur.delete(); m_pend = 1'b0; m_word = '0; m_cnt = '0;
   endtask

   // One cycle: drive, compare every output to the model before the edge, then advance the model.
   task automatic step(input logic v, input logic [DW-1:0] d, input logic fl, input logic ff, input logic rs);
      logic          exp_rdy;
      logic          exp_push;
      logic [DW-1:0] b0;
      logic [DW-1:0] b1;
      logic [DW-1:0] b2;
      bus.s_valid = v; bus.s_data = d; bus.flush = fl; bus.fifo_full = ff; rst = rs;
      #3;
      exp_rdy  = !fl && (cur.size() < 2 || !m_pend || !ff);
      exp_push = m_pend && !ff;
      check("s_ready", 192'(bus.s_ready), 192'(exp_rdy));
      check("push", 192'(bus.push), 192'(exp_push));
      check("push_data", 192'(bus.push_data), 192'(m_word));
      check("beat_cnt", 192'(bus.beat_cnt), 192'(cur.size()));
      check("instr_count", 192'(bus.instr_count), 192'(m_cnt));
      if (bus.push) push_seen++;
      @(posedge clk);
      if (rs) begin
         cur.delete(); m_pend = 1'b0; m_word = '0; m_cnt = '0;
      end else begin
         if (exp_push) begin
            m_cnt++;
            m_pend = 1'b0;
         end
         if (fl) begin
            cur.delete();
         end else if (v && exp_rdy) begin
            cur.push_back(d);
            if (cur.size() == 3) begin
               b0 = cur[0]; b1 = cur[1]; b2 = cur[2];
               m_word = word(b0, b1, b2);
               m_pend = 1'b1;
               cur.delete();
            end
         end
      end
      #1;
   endtask

   task automatic instr(input logic [DW-1:0] b0, input logic [DW-1:0] b1, input logic [DW-1:0] b2,
                        input logic ff);
      step(1'b1, b0, 1'b0, ff, 1'b0);
      step(1'b1, b1, 1'b0, ff, 1'b0);
      step(1'b1, b2, 1'b0, ff, 1'b0);
   endtask

   initial begin
      logic [DW-1:0] a0, a1, a2, d0, d1, d2, d3, d4, d5;
      logic [IW-1:0] w1, w2, w3;
      int            ps0;
      n_checks = 0; n_fail = 0; push_seen = 0;

      do_reset();
      do_reset();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0, 1'b0);

      // Directed table: first instruction, then a 5-cycle FIFO-full stall with the next instruction racing in.
      a0 = 64'h1111111111111111; a1 = 64'h2222222222222222; a2 = 64'hAAAAAAAA33333333;
      d0 = 64'h0123456789ABCDEF; d1 = 64'hFEDCBA9876543210; d2 = 64'hDEADBEEFCAFEF00D;
      d3 = 64'h0F0F0F0F0F0F0F0F; d4 = 64'h7777666655554444; d5 = 64'h5555AAAA12345678;
      w1 = 160'h33333333_2222222222222222_1111111111111111;
      w2 = word(d0, d1, d2);
      w3 = word(d3, d4, d5);
      tbl[0]  = mk(1, a0, 0, 1, 0, '0, 0, 0);
      tbl[1]  = mk(1, a1, 0, 1, 0, '0, 1, 0);
      tbl[2]  = mk(1, a2, 0, 1, 0, '0, 2, 0);
      tbl[3]  = mk(0, '0, 0, 1, 1, w1, 0, 0);
      tbl[4]  = mk(0, '0, 0, 1, 0, w1, 0, 1);
      tbl[5]  = mk(1, d0, 0, 1, 0, w1, 0, 1);
      tbl[6]  = mk(1, d1, 0, 1, 0, w1, 1, 1);
      tbl[7]  = mk(1, d2, 0, 1, 0, w1, 2, 1);
      tbl[8]  = mk(1, d3, 1, 1, 0, w2, 0, 1);
      tbl[9]  = mk(1, d4, 1, 1, 0, w2, 1, 1);
      tbl[10] = mk(1, d5, 1, 0, 0, w2, 2, 1);
      tbl[11] = mk(1, d5, 1, 0, 0, w2, 2, 1);
      tbl[12] = mk(1, d5, 1, 0, 0, w2, 2, 1);
      tbl[13] = mk(1, d5, 0, 1, 1, w2, 2, 1);
      tbl[14] = mk(0, '0, 0, 1, 1, w3, 0, 2);
      tbl[15] = mk(0, '0, 0, 1, 0, w3, 0, 3);
      do_reset();
      for (int i = 0; i < 16; i++) begin
         bus.s_valid = tbl[i].v; bus.s_data = tbl[i].d; bus.flush = 1'b0; bus.fifo_full = tbl[i].ff;
         #3;
         check($sformatf("tbl%0d_s_ready", i), 192'(bus.s_ready), 192'(tbl[i].e_rdy));
         check($sformatf("tbl%0d_push", i), 192'(bus.push), 192'(tbl[i].e_push));
         check($sformatf("tbl%0d_push_data", i), 192'(bus.push_data), 192'(tbl[i].e_pd));
         check($sformatf("tbl%0d_beat_cnt", i), 192'(bus.beat_cnt), 192'(tbl[i].e_bc));
         check($sformatf("tbl%0d_instr_count", i), 192'(bus.instr_count), 192'(tbl[i].e_cnt));
         @(posedge clk); #1;
      end

      // Flush after two beats: only the three later beats form the pushed word.
      do_reset();
      step(1'b1, d0, 1'b0, 1'b0, 1'b0);
      step(1'b1, d1, 1'b0, 1'b0, 1'b0);
      step(1'b1, d2, 1'b1, 1'b0, 1'b0);
      check("flush_beat_cnt", 192'(bus.beat_cnt), 192'(0));
      ps0 = push_seen;
      instr(a0, a1, a2, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("flush_push_data", 192'(bus.push_data), 192'(w1));
      check("flush_push_cnt", 192'(push_seen - ps0), 192'(1));

      // Back-to-back beats: one instruction every three cycles.
      do_reset();
      ps0 = push_seen;
      for (int i = 0; i < 30; i++) step(1'b1, {$urandom, $urandom}, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("stream_pushes", 192'(push_seen - ps0), 192'(10));
      check("stream_instr_count", 192'(bus.instr_count), 192'(10));

      // Reset with a word pending and two beats of the next staged.
      do_reset();
      instr(d0, d1, d2, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      instr(d3, d4, d5, 1'b1);
      step(1'b1, a0, 1'b0, 1'b1, 1'b0);
      step(1'b1, a1, 1'b0, 1'b1, 1'b0);
      step(1'b1, a2, 1'b0, 1'b1, 1'b1);
      bus.s_valid = 1'b0; bus.fifo_full = 1'b0;
      #1;
      check("rst_push", 192'(bus.push), 192'(0));
      check("rst_beat_cnt", 192'(bus.beat_cnt), 192'(0));
      check("rst_instr_count", 192'(bus.instr_count), 192'(0));
      @(posedge clk); #1;

      // Counter wrap, starting from a preloaded count just below the top.
      do_reset();
      force dut.count_q = 16'hFFFE;
      #1;
      release dut.count_q;
      m_cnt = 16'hFFFE;
      @(posedge clk); #1;
      instr(d0, d1, d2, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("wrap_ffff", 192'(bus.instr_count), 192'(16'hFFFF));
      instr(d3, d4, d5, 1'b0);
      step(1'b0, '0, 1'b0, 1'b0, 1'b0);
      check("wrap_zero", 192'(bus.instr_count), 192'(0));

      // Random traffic, backpressure, flushes and occasional resets against the model.
      do_reset();
      for (int i = 0; i < 800; i++) begin
         step($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 19) == 0,
              $urandom_range(0, 2) == 0, $urandom_range(0, 199) == 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
